// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: returns cache hits and refills a missed line with a burst read.
// Optional macro ICACHE_EARLY_RESTART_EN returns the critical word as soon as it arrives.
module icache_refill_ctrl #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int WORDS_PER_LINE = 4
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] r_addr,
   input  logic [DATA_W-1:0] r_data,
   input  logic              hit,
   input  logic              request_valid,
   input  logic              r_valid,
   output logic              stall,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   output logic              mem_req_valid,
   output logic [ADDR_W-1:0] mem_req_addr,
   input  logic              mem_req_ready,
   input  logic              mem_resp_valid,
   input  logic [DATA_W-1:0] mem_resp_data,
   output logic              fill_we,
   output logic [ADDR_W-1:0] fill_addr,
   output logic [DATA_W-1:0] fill_data,
   output logic              fill_tag_we
);
   localparam int OFF_W = $clog2(WORDS_PER_LINE);
   typedef enum logic [1:0] {IDLE, REQ, FILL, RESP} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] line_base;
   logic [OFF_W-1:0] crit_off, beat;
   logic hit_go, miss_go, beat_go, last_beat, crit_beat;
`ifdef ICACHE_EARLY_RESTART_EN
   // served: critical word already returned, remaining beats fill in the background
   logic served;
   assign hit_go = request_valid && hit && r_valid && (state == IDLE || served);
   assign stall = (state != IDLE && !served) || (request_valid && !hit);
`else
   logic [DATA_W-1:0] crit_word;
   assign hit_go = request_valid && hit && r_valid && state == IDLE;
   assign stall = state != IDLE || (request_valid && !hit);
`endif
   assign miss_go = state == IDLE && request_valid && !hit;
   assign beat_go = state == FILL && mem_resp_valid;
   assign last_beat = beat == OFF_W'(WORDS_PER_LINE - 1);
   assign crit_beat = beat_go && beat == crit_off;
   assign mem_req_valid = state == REQ;
   assign mem_req_addr = line_base;
   always_comb begin
      state_n = state;
      case (state)
         IDLE: state_n = miss_go ? REQ : IDLE;
         REQ:  state_n = mem_req_ready ? FILL : REQ;
`ifdef ICACHE_EARLY_RESTART_EN
         FILL: state_n = (beat_go && last_beat) ? IDLE : FILL;
`else
         FILL: state_n = (beat_go && last_beat) ? RESP : FILL;
`endif
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state <= IDLE;
         line_base <= '0;
         crit_off <= '0;
         beat <= '0;
         core_rvalid <= 1'b0;
         core_rdata <= '0;
         fill_we <= 1'b0;
         fill_addr <= '0;
         fill_data <= '0;
         fill_tag_we <= 1'b0;
`ifdef ICACHE_EARLY_RESTART_EN
         served <= 1'b0;
`else
         crit_word <= '0;
`endif
      end else begin
         state <= state_n;
         fill_we <= beat_go;
         fill_tag_we <= beat_go && last_beat;
         if (miss_go) begin
            line_base <= r_addr & ~ADDR_W'(WORDS_PER_LINE * 4 - 1);
            crit_off <= r_addr[OFF_W+1:2];
         end
         if (beat_go) begin
            fill_addr <= line_base + ADDR_W'({beat, 2'b00});
            fill_data <= mem_resp_data;
            beat <= beat + OFF_W'(1);
         end
`ifdef ICACHE_EARLY_RESTART_EN
         served <= crit_beat || (served && !(beat_go && last_beat));
         core_rvalid <= hit_go || crit_beat;
         if (hit_go || crit_beat) core_rdata <= hit_go ? r_data : mem_resp_data;
`else
         if (crit_beat) crit_word <= mem_resp_data;
         core_rvalid <= hit_go || (beat_go && last_beat);
         // the critical beat may be the last one, so bypass crit_word in that case
         if (hit_go) core_rdata <= r_data;
         else if (beat_go && last_beat) core_rdata <= crit_beat ? mem_resp_data : crit_word;
`endif
      end
   end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: vector table, directed miss/reset sequences and randomized
// transactions checked against a transaction-level model of the refill controller.
module tb_icache_refill_ctrl;
`ifdef ICACHE_EARLY_RESTART_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   logic CLK = 1'b0, RESET = 1'b1;
   logic [31:0] r_addr = '0, r_data = '0, mem_resp_data = '0;
   logic hit = 0, request_valid = 0, r_valid = 0, mem_req_ready = 0, mem_resp_valid = 0;
   logic stall, core_rvalid, mem_req_valid, fill_we, fill_tag_we;
   logic [31:0] core_rdata, mem_req_addr, fill_addr, fill_data;
   int total = 0, bad = 0;
   logic [31:0] last_rdata = '0;

   always #5 CLK = ~CLK;

   icache_refill_ctrl dut (
      .CLK(CLK), .RESET(RESET), .r_addr(r_addr), .r_data(r_data), .hit(hit),
      .request_valid(request_valid), .r_valid(r_valid), .stall(stall),
      .core_rvalid(core_rvalid), .core_rdata(core_rdata), .mem_req_valid(mem_req_valid),
      .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
      .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .fill_we(fill_we),
      .fill_addr(fill_addr), .fill_data(fill_data), .fill_tag_we(fill_tag_we)
   );

   typedef struct {
      string name;
      logic rq, h, rv;
      logic [31:0] data;
      logic exp_rv;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      request_valid = 0; hit = 0; r_valid = 0; mem_req_ready = 0; mem_resp_valid = 0;
   endtask

   // one non-miss request in IDLE; response expected the next cycle
   task automatic apply_vec(input string name, input logic rq, input logic h, input logic rv,
                            input logic [31:0] data, input logic exp_rv);
      @(posedge CLK); #1;
      request_valid = rq; hit = h; r_valid = rv; r_data = data; r_addr = $urandom;
      #1 chk({name, "_stall"}, stall, 0);
      @(posedge CLK); #1;
      idle_inputs();
      if (exp_rv) last_rdata = data;
      chk({name, "_rvalid"}, core_rvalid, exp_rv);
      chk({name, "_rdata"}, core_rdata, last_rdata);
      chk({name, "_noreq"}, mem_req_valid, 0);
   endtask

   // gap: 0 beat every cycle, 1 alternate cycles, 2 random
   task automatic run_miss(input logic [31:0] addr, input logic [31:0] d [4], input int ready_dly,
                           input int gap, input bit follow_hit, input logic [31:0] hit_data);
      logic [31:0] lb, cw;
      int co, req_cycles, sent, fills, tags, rv;
      bit in_fill, go_fill, req_err, stall_err, tag_err, done, fin, beat;
      lb = addr & ~32'hF;
      co = int'(addr[3:2]);
      cw = d[co];
      req_cycles = 0; sent = 0; fills = 0; tags = 0; rv = 0;
      in_fill = 0; go_fill = 0; req_err = 0; stall_err = 0; tag_err = 0; done = 0;
      @(posedge CLK); #1;
      request_valid = 1; hit = 0; r_valid = $urandom_range(1); r_addr = addr; r_data = $urandom;
      #1 chk("miss_stall", stall, 1);
      for (int cyc = 0; cyc < 300 && !done; cyc++) begin
         @(posedge CLK); #1;
         request_valid = 0;
         in_fill = in_fill || go_fill;
         if (mem_req_valid) begin
            req_cycles++;
            if (mem_req_addr !== lb) req_err = 1;
         end
         if (fill_we) begin
            chk("fill_addr", fill_addr, lb + 32'(4 * fills));
            chk("fill_data", fill_data, d[fills & 3]);
            if (fill_tag_we !== (fills == 3)) tag_err = 1;
            if (fill_tag_we) tags++;
            fills++;
         end else if (fill_tag_we) tag_err = 1;
         if (core_rvalid) begin
            rv++;
            chk("resp_data", core_rdata, cw);
            chk("resp_after_fills", fills, EARLY ? co + 1 : 4);
            last_rdata = cw;
         end
         fin = fills == 4 && rv >= 1 && !core_rvalid && !fill_we;
         go_fill = mem_req_valid && req_cycles > ready_dly;
         mem_req_ready = go_fill;
         beat = gap == 0 || (gap == 1 && cyc % 2 == 0) || (gap == 2 && $urandom_range(1) == 1);
         if (in_fill && sent < 4) begin
            mem_resp_valid = beat;
            mem_resp_data = beat ? d[sent] : $urandom;
            if (beat) sent++;
         end else begin
            mem_resp_valid = $urandom_range(1);
            mem_resp_data = $urandom;
         end
         if (fin) begin
            if (follow_hit) begin
               request_valid = 1; hit = 1; r_valid = 1; r_data = hit_data;
            end
            #1 chk("stall_released", stall, 0);
            done = 1;
         end else begin
            #1 if (stall !== (EARLY ? rv == 0 : 1'b1)) stall_err = 1;
         end
      end
      chk("miss_done", done, 1);
      chk("req_addr_stable", req_err, 0);
      chk("req_cycles", req_cycles, ready_dly + 1);
      chk("fill_count", fills, 4);
      chk("tag_pulses", tags, 1);
      chk("tag_timing", tag_err, 0);
      chk("resp_count", rv, 1);
      chk("stall_profile", stall_err, 0);
      if (follow_hit) begin
         @(posedge CLK); #1;
         chk("post_miss_hit_rvalid", core_rvalid, 1);
         chk("post_miss_hit_rdata", core_rdata, hit_data);
         last_rdata = hit_data;
      end
      idle_inputs();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      vec_t tbl[6];
      logic [31:0] beats [4];
      logic [31:0] err;
      tbl[0] = '{"hit_deadbeef", 1, 1, 1, 32'hDEADBEEF, 1};
      tbl[1] = '{"hit_no_rvalid", 1, 1, 0, 32'h12345678, 0};
      tbl[2] = '{"no_request", 0, 1, 1, 32'h0BADF00D, 0};
      tbl[3] = '{"no_request_miss", 0, 0, 1, 32'h55AA55AA, 0};
      tbl[4] = '{"hit_zero", 1, 1, 1, 32'h00000000, 1};
      tbl[5] = '{"hit_ones", 1, 1, 1, 32'hFFFFFFFF, 1};

      #2;
      chk("reset_outs", {stall, core_rvalid, mem_req_valid, fill_we, fill_tag_we}, 0);
      chk("reset_rdata", core_rdata, 0);
      chk("reset_fill_addr", fill_addr, 0);
      chk("reset_req_addr", mem_req_addr, 0);
      repeat (2) @(posedge CLK);
      #1 RESET = 0;

      foreach (tbl[i]) apply_vec(tbl[i].name, tbl[i].rq, tbl[i].h, tbl[i].rv, tbl[i].data, tbl[i].exp_rv);

      beats = '{32'h11, 32'h22, 32'h33, 32'h44};
      run_miss(32'h00001238, beats, 3, 0, 0, 0);
      beats = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4};
      run_miss(32'h0000567C, beats, 0, 1, 0, 0);
      run_miss(32'hFFFFFFF4, beats, 1, 0, 1, 32'h600DCAFE);
`ifdef ICACHE_EARLY_RESTART_EN
      beats = '{32'hE0, 32'hE1, 32'hE2, 32'hE3};
      run_miss(32'h00003000, beats, 0, 0, 0, 0);
`endif

      // reset after two of four beats
      @(posedge CLK); #1;
      request_valid = 1; hit = 0; r_valid = 1; r_addr = 32'h00002008;
      @(posedge CLK); #1;
      request_valid = 0; mem_req_ready = 1;
      chk("rst_seq_req", mem_req_valid, 1);
      @(posedge CLK); #1;
      mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hA0;
      @(posedge CLK); #1;
      mem_resp_data = 32'hA1;
      @(posedge CLK); #1;
      chk("rst_seq_fill1", {fill_we, fill_tag_we}, 2'b10);
      chk("rst_seq_fill1_addr", fill_addr, 32'h00002004);
      mem_resp_valid = 0;
      #2 RESET = 1;
      #1;
      chk("async_rst_outs", {stall, core_rvalid, mem_req_valid, fill_we, fill_tag_we}, 0);
      chk("async_rst_data", fill_data | fill_addr | core_rdata | mem_req_addr, 0);
      @(posedge CLK); #1;
      RESET = 0; mem_resp_valid = 1; mem_resp_data = 32'hA2;
      err = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         err |= 32'({fill_we, fill_tag_we, core_rvalid, mem_req_valid, stall});
         mem_resp_data = 32'hA3;
      end
      idle_inputs();
      chk("late_beats_dropped", err, 0);
      last_rdata = 0;
      apply_vec("hit_after_reset", 1, 1, 1, 32'hCAFEF00D, 1);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(3) == 0) begin
            foreach (beats[k]) beats[k] = $urandom;
            run_miss($urandom, beats, $urandom_range(3), $urandom_range(2), 1'($urandom_range(1)), $urandom);
         end else begin
            logic rq, h, rv;
            rq = 1'($urandom_range(1)); h = 1'($urandom_range(1)); rv = 1'($urandom_range(1));
            if (rq && !h) h = 1;
            apply_vec("rand_vec", rq, h, rv, $urandom, rq && h && rv);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
